// File: rtl/uart_rx_framer_pkg.sv
// rtl/uart_rx_framer_pkg.sv - shared types and constants for the UART receive framer
package uart_rx_framer_pkg;

  // Frame assembly states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_e;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_N       = 10;
  localparam int DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// rtl/uart_rx_idle_timer.sv - inter-byte idle counter that flags an abandoned partial frame
module uart_rx_idle_timer
  import uart_rx_framer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Holds TIMEOUT-1 at most; expiry is taken on the cycle that would reach TIMEOUT
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A byte (clr) always wins over expiry so a late byte is never discarded
  assign expired = en && !clr && (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: restart on a byte, when disabled, or after firing
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!en || clr || expired) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - packs N received UART bytes into one frame; idle timeout under UART_RX_FRAMER_TIMEOUT_EN
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BYTE_W-1:0]     i_data,
  input  logic                  i_valid,
  input  logic                  i_frame_ready,
  output logic [N*BYTE_W-1:0]   o_frame,
  output logic                  o_frame_valid,
  output logic [$clog2(N)-1:0]  o_sel,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_timeout
);

  localparam int SEL_W = $clog2(N);

  logic [1:0]                   rst_sync_q;
  logic                         rst_sync_n;
  state_e                       state_q;
  logic [SEL_W-1:0]             sel_q;
  logic [N-1:0][BYTE_W-1:0]     frame_q;
  logic                         valid_q;
  logic                         busy_q;
  logic                         overrun_q;

  // Reset asserts immediately but releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  logic timer_expired;
  logic timeout_q;

  uart_rx_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_sync_n),
    .clr     (i_valid),
    .en      (state_q == COLLECT),
    .expired (timer_expired)
  );

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Frame assembly FSM; every output comes straight from a register
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            frame_q[0] <= i_data;
            sel_q      <= SEL_W'(1);
            busy_q     <= 1'b1;
            state_q    <= COLLECT;
          end
        end

        COLLECT: begin
          if (i_valid) begin
            frame_q[sel_q] <= i_data;
            if (sel_q == SEL_W'(N - 1)) begin
              sel_q   <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              state_q <= FULL;
            end else begin
              sel_q <= sel_q + SEL_W'(1);
            end
`ifdef UART_RX_FRAMER_TIMEOUT_EN
          end else if (timer_expired) begin
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
`endif
          end
        end

        FULL: begin
          if (i_frame_ready) begin
            valid_q <= 1'b0;
            if (i_valid) begin
              // Handshake and first byte of the next frame share this cycle
              frame_q[0] <= i_data;
              sel_q      <= SEL_W'(1);
              busy_q     <= 1'b1;
              state_q    <= COLLECT;
            end else begin
              sel_q   <= '0;
              state_q <= IDLE;
            end
          end else if (i_valid) begin
            // Frame is still owned by the consumer; the byte has nowhere to go
            overrun_q <= 1'b1;
          end
        end

        default: begin
          sel_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_frame       = frame_q;
  assign o_frame_valid = valid_q;
  assign o_sel         = sel_q;
  assign o_busy        = busy_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - directed self-checking bench for uart_rx_framer (N=10, TIMEOUT=20)
module tb_uart_rx_framer;

  localparam int N       = 10;
  localparam int TIMEOUT = 20;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam int PAD = 4;
`else
  localparam int PAD = 1;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           i_data;
  logic                 i_valid;
  logic                 i_frame_ready;
  logic [N*8-1:0]       o_frame;
  logic                 o_frame_valid;
  logic [$clog2(N)-1:0] o_sel;
  logic                 o_busy;
  logic                 o_overrun;
  logic                 o_timeout;

  int checks;
  int errors;

  uart_rx_framer #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .i_frame_ready (i_frame_ready),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .o_sel         (o_sel),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .o_timeout     (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    i_data        = 8'h00;
    i_valid       = 1'b0;
    i_frame_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 80'(o_frame_valid), 80'd0);
    check("rst_busy", 80'(o_busy), 80'd0);
    check("rst_sel", 80'(o_sel), 80'd0);
    check("rst_frame", o_frame, 80'd0);
    check("rst_overrun", 80'(o_overrun), 80'd0);
    check("rst_timeout", 80'(o_timeout), 80'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_busy", 80'(o_busy), 80'd0);

    // Bytes 0x00..0x09 with ready held high; ready is ignored while collecting
    i_frame_ready = 1'b1;
    for (int k = 0; k < N - 1; k++) begin
      send(8'(k));
      check($sformatf("f1_sel_%0d", k), 80'(o_sel), 80'(k + 1));
      check($sformatf("f1_busy_%0d", k), 80'(o_busy), 80'd1);
      check($sformatf("f1_nvalid_%0d", k), 80'(o_frame_valid), 80'd0);
    end
    send(8'h09);
    check("f1_valid", 80'(o_frame_valid), 80'd1);
    check("f1_frame", o_frame, 80'h09080706050403020100);
    check("f1_sel_full", 80'(o_sel), 80'd0);
    check("f1_busy_full", 80'(o_busy), 80'd0);
    tick();
    check("f1_valid_drop", 80'(o_frame_valid), 80'd0);
    check("f1_idle_sel", 80'(o_sel), 80'd0);
    check("f1_idle_busy", 80'(o_busy), 80'd0);

    // Overrun while FULL and not accepted
    i_frame_ready = 1'b0;
    for (int k = 0; k < N; k++) send(8'(8'h10 + k));
    check("f2_valid", 80'(o_frame_valid), 80'd1);
    check("f2_frame", o_frame, 80'h19181716151413121110);
    send(8'hAA);
    check("ovr_pulse", 80'(o_overrun), 80'd1);
    check("ovr_valid", 80'(o_frame_valid), 80'd1);
    check("ovr_frame", o_frame, 80'h19181716151413121110);
    tick();
    check("ovr_clear", 80'(o_overrun), 80'd0);
    check("ovr_still_full", 80'(o_frame_valid), 80'd1);
    check("ovr_frame_hold", o_frame, 80'h19181716151413121110);

    // Accept and first byte of the next frame in the same cycle
    i_frame_ready = 1'b1;
    send(8'h55);
    i_frame_ready = 1'b0;
    check("hs_valid", 80'(o_frame_valid), 80'd0);
    check("hs_busy", 80'(o_busy), 80'd1);
    check("hs_sel", 80'(o_sel), 80'd1);
    check("hs_byte0", 80'(o_frame[7:0]), 80'h55);
    check("hs_overrun", 80'(o_overrun), 80'd0);
    for (int k = 1; k < N; k++) send(8'(k));
    check("f3_valid", 80'(o_frame_valid), 80'd1);
    check("f3_frame", o_frame, 80'h09080706050403020155);
    i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
    check("f3_release", 80'(o_frame_valid), 80'd0);

    // Idle gap after three bytes
    send(8'hA0);
    send(8'hA1);
    send(8'hA2);
    check("to_sel3", 80'(o_sel), 80'd3);
`ifdef UART_RX_FRAMER_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      check($sformatf("to_quiet_%0d", k), 80'(o_timeout), 80'd0);
    end
    check("to_busy_before", 80'(o_busy), 80'd1);
    tick();
    check("to_pulse", 80'(o_timeout), 80'd1);
    check("to_sel0", 80'(o_sel), 80'd0);
    check("to_busy0", 80'(o_busy), 80'd0);
    tick();
    check("to_pulse_end", 80'(o_timeout), 80'd0);
    send(8'hB0);
    check("to_next_sel", 80'(o_sel), 80'd1);
    check("to_next_byte0", 80'(o_frame[7:0]), 80'hB0);
`else
    for (int k = 0; k < TIMEOUT + 5; k++) tick();
    check("nto_timeout", 80'(o_timeout), 80'd0);
    check("nto_busy", 80'(o_busy), 80'd1);
    check("nto_sel", 80'(o_sel), 80'd3);
    send(8'hB0);
    check("nto_next_sel", 80'(o_sel), 80'd4);
    check("nto_slot3", 80'(o_frame[31:24]), 80'hB0);
`endif

    // Asynchronous reset with five bytes in the partial frame
    for (int k = 0; k < PAD; k++) send(8'(8'hE0 + k));
    check("mid_sel5", 80'(o_sel), 80'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 80'(o_frame_valid), 80'd0);
    check("arst_busy", 80'(o_busy), 80'd0);
    check("arst_sel", 80'(o_sel), 80'd0);
    check("arst_frame", o_frame, 80'd0);
    check("arst_overrun", 80'(o_overrun), 80'd0);
    check("arst_timeout", 80'(o_timeout), 80'd0);
    for (int k = 0; k < TIMEOUT + 3; k++) tick();
    check("arst_hold_timeout", 80'(o_timeout), 80'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("arst_rel_timeout", 80'(o_timeout), 80'd0);
    check("arst_rel_sel", 80'(o_sel), 80'd0);

    // Fresh frame after reset
    for (int k = 0; k < N; k++) send(8'(8'hC0 + k));
    check("f4_valid", 80'(o_frame_valid), 80'd1);
    check("f4_frame", o_frame, 80'hC9C8C7C6C5C4C3C2C1C0);
    check("f4_timeout", 80'(o_timeout), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
